up_count_sync_t_ff: RTL and testbench
=====================================

Name: up_count_sync_t_ff

Overview:
- Synchronous, parameterised modulo-N up counter. It is the counting-up counterpart to the team's ripple down counter.
- Built as a single-clock T-flip-flop chain: bit i toggles when en is high and all lower bits are 1. Wrap-around is forced at MODULUS-1.
- Adds parallel load, cascade carry-in/carry-out, a terminal-count flag and a sticky overflow flag.
- Used as a timebase / event counter; instances cascade via cin/cout.

Parameters:
WIDTH, 4, counter width in bits (1..16)
MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH

Ports:
clk  input  1  rising-edge clock, sole clock
r  input  1  asynchronous, active-high reset
en  input  1  count enable (synchronous)
cin  input  1  cascade carry-in; counting occurs only when en && cin (tie 1 if unused)
ld  input  1  synchronous parallel load strobe
d  input  WIDTH  load value
clr_ovf  input  1  synchronous clear of sticky overflow flag
q  output  WIDTH  registered count
qbar  output  WIDTH  bitwise complement of q (combinational)
tc  output  1  terminal count: q == MODULUS-1 (combinational from q)
cout  output  1  cascade carry-out: tc && en && cin (combinational)
ovf  output  1  sticky overflow; set on any wrap MODULUS-1 -> 0
ld_err  output  1  registered one-cycle pulse: last load value was out of range

Behaviour:
- Reset values:
  - r high, at any time, asynchronously forces q=0, ovf=0, ld_err=0.
  - Consequently qbar = all ones, tc=0, cout=0.
  - Counting resumes on the first rising clk edge after r deasserts.
- Priority on each rising clk edge: r > ld > (en && cin) > hold.
- Load:
  - ld=1 and d < MODULUS: q <= d, ld_err <= 0.
  - ld=1 and d >= MODULUS: q <= 0, ld_err <= 1 for exactly one cycle.
  - A load never sets or clears ovf.
- Count:
  - ld=0, en=1, cin=1, q < MODULUS-1: q <= q+1.
  - ld=0, en=1, cin=1, q == MODULUS-1: q <= 0 and ovf <= 1.
  - Next-state is computed as T-flip-flop toggle enables: T[0] = step; T[i] = step && &q[i-1:0].
  - The wrap is forced by a synchronous clear when tc && step, which overrides the toggles.
  - When MODULUS == 2^WIDTH, the natural roll-over and the forced clear give the same result.
- Hold: ld=0 and (en=0 or cin=0) -> q unchanged.
- ld_err returns to 0 on every edge without an out-of-range load.
- ovf:
  - Cleared by clr_ovf=1 on an edge.
  - If a wrap and clr_ovf occur on the same edge, set wins (ovf=1).
- Latency:
  - q changes one clk edge after the qualifying inputs are sampled.
  - tc, cout and qbar follow q combinationally (zero cycles).
- Cascading:
  - Connect the low stage's cout to the high stage's cin, with en shared.
  - The high stage increments on the same edge the low stage wraps.
  - No ripple clocking: every stage uses clk.
- Reset mid-operation: asynchronous clear takes effect immediately regardless of ld/en. A load or count pending in the same cycle is discarded.
- No internal state other than q, ovf and ld_err.

Test Plan:
- Reset/idle: assert r mid-count at q=9 between edges -> q=0, qbar=4'hF, ovf=0, ld_err=0 immediately. en=0 for 5 edges -> q stays 0.
- Full count, default params: en=cin=1 for 17 edges from 0 -> q runs 0..15,0,1. tc=1 only while q=15. ovf rises on the 15->0 edge and stays 1.
- Modulo 10 (MODULUS=10): count 12 edges from 0 -> q 0..9,0,1,2. cout high while q=9. ovf set on the 9->0 edge. clr_ovf pulse -> ovf=0. Then clr_ovf held through the next 9->0 edge -> ovf=1 (set wins).
- Load: at q=3, ld=1 with en=1 and d=7 -> q=7 (load beats count), ld_err=0. MODULUS=10 with d=12 -> q=0, ld_err=1 for one cycle, ovf unchanged. Load at q=9 with en=1 -> no ovf set.
- Cascade: two MODULUS=10 instances, low cout -> high cin, 25 enabled edges from 0 -> {high,low} = 2,5. High increments only on low's 9->0 edges. Low cin=0 for 3 edges -> both hold.
- Gating: en=1, cin=0 -> q holds and cout=0 even at tc. en toggled every cycle for 8 edges -> q advances by exactly 4.

Source files
------------

// File: rtl/up_count_sync_t_ff.sv
// rtl/up_count_sync_t_ff.sv - synchronous modulo-N up counter built as a T flip-flop chain
// Parallel load, cascade carry-in/out, terminal count, sticky overflow and load range error.
module up_count_sync_t_ff #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic             cin,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             cout,
  output logic             ovf,
  output logic             ld_err
);

  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             step;
  logic             wrap;
  logic             d_in_range;
  logic             lower_ones;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_toggled;

  assign step       = en && cin;
  assign tc         = (q == TERM);
  assign cout       = tc && step;
  assign qbar       = ~q;
  assign wrap       = !ld && step && tc;
  // One extra bit so MODULUS == 2^WIDTH is representable in the range check.
  assign d_in_range = ({1'b0, d} < MOD_EXT);

  // Bit i toggles when stepping and every lower bit is already 1.
  always_comb begin
    lower_ones = 1'b1;
    t          = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]       = step && lower_ones;
      lower_ones = lower_ones && q[i];
    end
  end

  assign q_toggled = q ^ t;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q      <= '0;
      ovf    <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      ld_err <= 1'b0;
      if (ld) begin
        if (d_in_range) begin
          q <= d;
        end else begin
          q      <= '0;
          ld_err <= 1'b1;
        end
      end else if (wrap) begin
        q <= '0;
      end else begin
        // Toggle vector is all zero when not stepping, so this also covers hold.
        q <= q_toggled;
      end
      if (wrap) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_up_count_sync_t_ff.sv
// tb/tb_up_count_sync_t_ff.sv - scoreboard bench for up_count_sync_t_ff
module tb_up_count_sync_t_ff;

    logic clk = 1'b0;
    logic r;
    always #5 clk = ~clk;

    logic       en_a, cin_a, ld_a, clr_a;
    logic [3:0] d_a, q_a, qbar_a;
    logic       tc_a, cout_a, ovf_a, lderr_a;

    logic       en_b, cin_b, ld_b, clr_b;
    logic [3:0] d_b, q_b, qbar_b;
    logic       tc_b, cout_b, ovf_b, lderr_b;

    logic       en_c, cin_c;
    logic [3:0] q_lo, qbar_lo, q_hi, qbar_hi;
    logic       tc_lo, cout_lo, ovf_lo, lderr_lo;
    logic       tc_hi, cout_hi, ovf_hi, lderr_hi;

    logic       done = 1'b0;

    up_count_sync_t_ff #(.WIDTH(4), .MODULUS(16)) dut_a (
        .clk(clk), .r(r), .en(en_a), .cin(cin_a), .ld(ld_a), .d(d_a), .clr_ovf(clr_a),
        .q(q_a), .qbar(qbar_a), .tc(tc_a), .cout(cout_a), .ovf(ovf_a), .ld_err(lderr_a)
    );

    up_count_sync_t_ff #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk(clk), .r(r), .en(en_b), .cin(cin_b), .ld(ld_b), .d(d_b), .clr_ovf(clr_b),
        .q(q_b), .qbar(qbar_b), .tc(tc_b), .cout(cout_b), .ovf(ovf_b), .ld_err(lderr_b)
    );

    up_count_sync_t_ff #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk(clk), .r(r), .en(en_c), .cin(cin_c), .ld(1'b0), .d(4'd0), .clr_ovf(1'b0),
        .q(q_lo), .qbar(qbar_lo), .tc(tc_lo), .cout(cout_lo), .ovf(ovf_lo), .ld_err(lderr_lo)
    );

    up_count_sync_t_ff #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .clk(clk), .r(r), .en(en_c), .cin(cout_lo), .ld(1'b0), .d(4'd0), .clr_ovf(1'b0),
        .q(q_hi), .qbar(qbar_hi), .tc(tc_hi), .cout(cout_hi), .ovf(ovf_hi), .ld_err(lderr_hi)
    );

    localparam int A_Q = 0, A_QBAR = 1, A_TC = 2, A_COUT = 3, A_OVF = 4, A_LDERR = 5;
    localparam int B_Q = 10, B_TC = 11, B_COUT = 12, B_OVF = 13, B_LDERR = 14;
    localparam int C_LO = 20, C_HI = 21, C_COUT = 22;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      sample_ev;
    int        checks   = 0;
    int        failures = 0;

    function automatic logic [31:0] actual(int s);
        case (s)
            A_Q:     return 32'(q_a);
            A_QBAR:  return 32'(qbar_a);
            A_TC:    return 32'(tc_a);
            A_COUT:  return 32'(cout_a);
            A_OVF:   return 32'(ovf_a);
            A_LDERR: return 32'(lderr_a);
            B_Q:     return 32'(q_b);
            B_TC:    return 32'(tc_b);
            B_COUT:  return 32'(cout_b);
            B_OVF:   return 32'(ovf_b);
            B_LDERR: return 32'(lderr_b);
            C_LO:    return 32'(q_lo);
            C_HI:    return 32'(q_hi);
            C_COUT:  return 32'(cout_lo);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin
        sb_entry_t e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e.sig);
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s actual=%0d required=%0d at t=%0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        #20000;
        if (!done) begin
            failures++;
            $display("FAIL timeout: wait expired before stimulus completed at t=%0t", $time);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic expect_sig(string n, int s, int v);
        sb.push_back('{n, s, 32'(v)});
    endtask

    task automatic sample();
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1'b1;
        en_a = 0; cin_a = 1; ld_a = 0; d_a = 0; clr_a = 0;
        en_b = 0; cin_b = 1; ld_b = 0; d_b = 0; clr_b = 0;
        en_c = 0; cin_c = 1;
        @(negedge clk);
        @(negedge clk);
        r = 1'b0;

        expect_sig("rst_q", A_Q, 0);
        expect_sig("rst_qbar", A_QBAR, 15);
        expect_sig("rst_tc", A_TC, 0);
        expect_sig("rst_cout", A_COUT, 0);
        expect_sig("rst_ovf", A_OVF, 0);
        expect_sig("rst_lderr", A_LDERR, 0);
        sample();

        en_a = 1;
        for (int i = 0; i < 9; i++) tick();
        expect_sig("pre_rst_q9", A_Q, 9);
        sample();
        #2;
        r = 1'b1;
        #1;
        checks++;
        if (q_a !== 4'd0 || qbar_a !== 4'hF || ovf_a !== 1'b0 || lderr_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_state q=%0d qbar=%0d ovf=%0b ld_err=%0b at t=%0t",
                     q_a, qbar_a, ovf_a, lderr_a, $time);
        end
        expect_sig("async_rst_q", A_Q, 0);
        expect_sig("async_rst_qbar", A_QBAR, 15);
        expect_sig("async_rst_ovf", A_OVF, 0);
        expect_sig("async_rst_lderr", A_LDERR, 0);
        sample();
        @(negedge clk);
        r = 1'b0;
        en_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_sig("idle_q", A_Q, 0);
            sample();
        end

        en_a = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            expect_sig("cnt16_q", A_Q, (i + 1) % 16);
            expect_sig("cnt16_tc", A_TC, ((i + 1) % 16 == 15) ? 1 : 0);
            expect_sig("cnt16_ovf", A_OVF, (i + 1 >= 16) ? 1 : 0);
            sample();
        end
        en_a = 0;

        ld_a = 1; d_a = 4'd3;
        tick();
        expect_sig("ld_q3", A_Q, 3);
        sample();
        en_a = 1; d_a = 4'd7;
        tick();
        expect_sig("ld_over_cnt_q", A_Q, 7);
        expect_sig("ld_over_cnt_lderr", A_LDERR, 0);
        sample();
        en_a = 0; d_a = 4'd15;
        tick();
        ld_a = 0;
        expect_sig("ld_q15_tc", A_TC, 1);
        sample();

        en_a = 1; cin_a = 0;
        #1;
        expect_sig("gate_cout", A_COUT, 0);
        sample();
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sig("gate_hold_q", A_Q, 15);
            sample();
        end
        en_a = 0; cin_a = 1;
        #1;
        expect_sig("cout_en_low", A_COUT, 0);
        sample();
        en_a = 1;
        #1;
        expect_sig("cout_at_tc", A_COUT, 1);
        sample();
        en_a = 0;

        ld_a = 1; d_a = 4'd0;
        tick();
        ld_a = 0;
        for (int i = 0; i < 8; i++) begin
            en_a = (i % 2 == 0);
            tick();
        end
        en_a = 0;
        expect_sig("toggle_en_q", A_Q, 4);
        sample();
        clr_a = 1;
        tick();
        clr_a = 0;
        expect_sig("clr_ovf_a", A_OVF, 0);
        sample();

        en_b = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_sig("cnt10_q", B_Q, (i + 1) % 10);
            expect_sig("cnt10_cout", B_COUT, ((i + 1) % 10 == 9) ? 1 : 0);
            expect_sig("cnt10_ovf", B_OVF, (i + 1 >= 10) ? 1 : 0);
            sample();
        end
        en_b = 0;
        clr_b = 1;
        tick();
        expect_sig("clr_ovf_b", B_OVF, 0);
        sample();
        clr_b = 0; ld_b = 1; d_b = 4'd8;
        tick();
        ld_b = 0; en_b = 1; clr_b = 1;
        tick();
        expect_sig("setwin_q9", B_Q, 9);
        expect_sig("setwin_pre_ovf", B_OVF, 0);
        sample();
        tick();
        expect_sig("setwin_q0", B_Q, 0);
        expect_sig("setwin_ovf", B_OVF, 1);
        sample();
        en_b = 0; clr_b = 0;

        ld_b = 1; d_b = 4'd12;
        tick();
        ld_b = 0;
        expect_sig("ld12_q", B_Q, 0);
        expect_sig("ld12_lderr", B_LDERR, 1);
        expect_sig("ld12_ovf_kept", B_OVF, 1);
        sample();
        tick();
        expect_sig("lderr_pulse_end", B_LDERR, 0);
        sample();
        ld_b = 1; d_b = 4'd10;
        tick();
        expect_sig("ld10_lderr", B_LDERR, 1);
        expect_sig("ld10_q", B_Q, 0);
        sample();
        d_b = 4'd9; clr_b = 1;
        tick();
        clr_b = 0;
        expect_sig("ld9_lderr", B_LDERR, 0);
        expect_sig("ld9_q", B_Q, 9);
        expect_sig("ld9_ovf_clr", B_OVF, 0);
        sample();
        d_b = 4'd5; en_b = 1;
        tick();
        ld_b = 0; en_b = 0;
        expect_sig("ld_at9_q", B_Q, 5);
        expect_sig("ld_at9_ovf", B_OVF, 0);
        sample();

        en_c = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            expect_sig("casc_lo", C_LO, (i + 1) % 10);
            expect_sig("casc_hi", C_HI, (i + 1) / 10);
            sample();
        end
        cin_c = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sig("casc_hold_lo", C_LO, 5);
            expect_sig("casc_hold_hi", C_HI, 2);
            expect_sig("casc_hold_cout", C_COUT, 0);
            sample();
        end

        #5;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL unchecked expectations remaining=%0d", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
